// File: rtl/seg_scan_driver_if.sv
// Bus bundle between a host and the 7-segment scan driver.
// The host side loads values and reads back the per-slot digit drive.
interface seg_scan_driver_if;
  logic [31:0] data_in;
  logic        load;
  logic        blank_lz;
  logic [7:0]  dp_mask;
  logic [3:0]  code;
  logic [7:0]  an;
  logic        dp;
  logic        blank;
  logic        frame;

  modport master (
    output data_in, load, blank_lz, dp_mask,
    input  code, an, dp, blank, frame
  );

  modport slave (
    input  data_in, load, blank_lz, dp_mask,
    output code, an, dp, blank, frame
  );
endinterface

// File: rtl/seg_scan_driver.sv
// Time-multiplexed scan controller for an 8-digit common-anode 7-segment display.
// New values are latched into a shadow register and committed only at frame wrap.
module seg_scan_driver #(
  parameter int CLK_DIV = 100000,
  parameter int DIGITS  = 8
) (
  input  logic              clk,
  input  logic              rst,
  seg_scan_driver_if.slave  bus
);

  localparam int               CNT_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);
  localparam logic [2:0]       IDX_MAX = 3'(DIGITS - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [31:0]      disp_q, disp_d;
  logic [31:0]      shadow_q, shadow_d;
  logic             pending_q, pending_d;
  logic [3:0]       code_q, code_d;
  logic [7:0]       an_q, an_d;
  logic             dp_q, dp_d;
  logic             blank_q, blank_d;
  logic             frame_q, frame_d;

  logic             tick;
  logic             wrap;
  logic             lz_blank;
  logic [7:0]       nib_nz;

  always_comb begin
    tick  = (cnt_q == CNT_MAX);
    wrap  = tick && (idx_q == IDX_MAX);
    cnt_d = tick ? '0 : cnt_q + 1'b1;
    idx_d = idx_q;
    if (tick) begin
      idx_d = wrap ? 3'd0 : idx_q + 3'd1;
    end
  end

  // A load coinciding with the wrap tick bypasses the shadow so it shows immediately.
  always_comb begin
    shadow_d  = bus.load ? bus.data_in : shadow_q;
    disp_d    = disp_q;
    pending_d = pending_q;
    if (wrap) begin
      pending_d = 1'b0;
      if (bus.load) begin
        disp_d = bus.data_in;
      end else if (pending_q) begin
        disp_d = shadow_q;
      end
    end else if (bus.load) begin
      pending_d = 1'b1;
    end
  end

  // Nibbles beyond the active digit count never hold off blanking.
  for (genvar gi = 0; gi < 8; gi++) begin : g_nib
    assign nib_nz[gi] = (gi < DIGITS) && (disp_d[4*gi +: 4] != 4'h0);
  end

  always_comb begin
    lz_blank = bus.blank_lz && (idx_d != 3'd0);
    for (int i = 0; i < 8; i++) begin
      if ((i >= int'(idx_d)) && nib_nz[i]) begin
        lz_blank = 1'b0;
      end
    end

    code_d  = code_q;
    an_d    = an_q;
    dp_d    = dp_q;
    blank_d = blank_q;
    frame_d = wrap;
    if (tick) begin
      code_d  = disp_d[4*idx_d +: 4];
      blank_d = lz_blank;
      an_d    = lz_blank ? 8'hFF : ~(8'h01 << idx_d);
      dp_d    = lz_blank | ~bus.dp_mask[idx_d];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      idx_q     <= 3'd0;
      disp_q    <= 32'h0;
      shadow_q  <= 32'h0;
      pending_q <= 1'b0;
      code_q    <= 4'h0;
      an_q      <= 8'hFE;
      dp_q      <= 1'b1;
      blank_q   <= 1'b0;
      frame_q   <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      disp_q    <= disp_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      code_q    <= code_d;
      an_q      <= an_d;
      dp_q      <= dp_d;
      blank_q   <= blank_d;
      frame_q   <= frame_d;
    end
  end

  assign bus.code  = code_q;
  assign bus.an    = an_q;
  assign bus.dp    = dp_q;
  assign bus.blank = blank_q;
  assign bus.frame = frame_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: an 8-digit/4-cycle-slot instance checked frame by frame
// from a scoreboard, and a 3-digit/1-cycle-slot instance checked cycle by cycle.
module tb_seg_scan_driver;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;

  always #5 clk = ~clk;

  seg_scan_driver_if ifa ();
  seg_scan_driver_if ifb ();

  seg_scan_driver #(.CLK_DIV(4), .DIGITS(8)) dut_a (
    .clk (clk),
    .rst (rst_a),
    .bus (ifa)
  );

  seg_scan_driver #(.CLK_DIV(1), .DIGITS(3)) dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (ifb)
  );

  typedef struct {
    logic [3:0] code;
    logic [7:0] an;
    logic       dp;
    logic       blank;
  } slot_t;

  typedef struct {
    logic [31:0] value;
    logic        blz;
    logic [7:0]  dpm;
    logic [7:0]  blank_mask;
  } vec_t;

  typedef struct {
    logic       blz;
    logic [3:0] code;
    logic [7:0] an;
    logic       dp;
    logic       blank;
    logic       frame;
  } brow_t;

  localparam int NV = 7;
  localparam int NB = 11;

  vec_t       vtab [NV];
  brow_t      btab [NB];
  logic [7:0] an_onehot [8];
  slot_t      exp_q [$];

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic slot_t mk_slot(input logic [31:0] v, input int d,
                                    input logic bl, input logic [7:0] dpm);
    slot_t s;
    s.code  = v[4*d +: 4];
    s.blank = bl;
    s.an    = bl ? 8'hFF : an_onehot[d];
    s.dp    = bl ? 1'b1 : ~dpm[d];
    return s;
  endfunction

  task automatic push_frame(input logic [31:0] v, input logic [7:0] mask, input logic [7:0] dpm);
    for (int d = 0; d < 8; d++) exp_q.push_back(mk_slot(v, d, mask[d], dpm));
  endtask

  task automatic wait_frame_a(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (ifa.frame === 1'b1) seen = 1'b1;
    end
    chk({tag, " frame seen"}, 32'(seen), 32'd1);
  endtask

  // Starts at the first cycle of digit 0; each digit must hold for exactly 4 cycles.
  task automatic check_frame_a(input string tag);
    slot_t s;
    for (int d = 0; d < 8; d++) begin
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL %s: scoreboard empty at digit %0d", tag, d);
        return;
      end
      s = exp_q.pop_front();
      for (int c = 0; c < 4; c++) begin
        if (d != 0 || c != 0) begin
          @(negedge clk);
          chk($sformatf("%s d%0d c%0d frame", tag, d, c), 32'(ifa.frame), 32'd0);
        end
        chk($sformatf("%s d%0d c%0d {code,an,dp,blank}", tag, d, c),
            32'({ifa.code, ifa.an, ifa.dp, ifa.blank}),
            32'({s.code, s.an, s.dp, s.blank}));
      end
    end
  endtask

  initial begin
    logic [31:0] prev;
    int          lead;

    an_onehot = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};

    vtab[0] = '{32'h89ABCDEF, 1'b0, 8'h00, 8'h00};
    vtab[1] = '{32'h00000012, 1'b1, 8'h00, 8'hFC};
    vtab[2] = '{32'h00000000, 1'b1, 8'hFF, 8'hFE};
    vtab[3] = '{32'h00F00000, 1'b1, 8'h21, 8'hC0};
    vtab[4] = '{32'h10000000, 1'b1, 8'h80, 8'h00};
    vtab[5] = '{32'h00000012, 1'b0, 8'h04, 8'h00};
    vtab[6] = '{32'h0000A000, 1'b1, 8'h10, 8'hF0};

    // value 0x021 on 3 digits, dp_mask 0x02; blz changes live between rows
    btab[0]  = '{1'b0, 4'h0, 8'hFD, 1'b0, 1'b0, 1'b0};
    btab[1]  = '{1'b0, 4'h0, 8'hFB, 1'b1, 1'b0, 1'b0};
    btab[2]  = '{1'b0, 4'h1, 8'hFE, 1'b1, 1'b0, 1'b1};
    btab[3]  = '{1'b0, 4'h2, 8'hFD, 1'b0, 1'b0, 1'b0};
    btab[4]  = '{1'b0, 4'h0, 8'hFB, 1'b1, 1'b0, 1'b0};
    btab[5]  = '{1'b1, 4'h1, 8'hFE, 1'b1, 1'b0, 1'b1};
    btab[6]  = '{1'b1, 4'h2, 8'hFD, 1'b0, 1'b0, 1'b0};
    btab[7]  = '{1'b1, 4'h0, 8'hFF, 1'b1, 1'b1, 1'b0};
    btab[8]  = '{1'b1, 4'h1, 8'hFE, 1'b1, 1'b0, 1'b1};
    btab[9]  = '{1'b0, 4'h2, 8'hFD, 1'b0, 1'b0, 1'b0};
    btab[10] = '{1'b0, 4'h0, 8'hFB, 1'b1, 1'b0, 1'b0};

    rst_a = 1'b1;
    rst_b = 1'b1;
    ifa.data_in = 32'h0; ifa.load = 1'b0; ifa.blank_lz = 1'b0; ifa.dp_mask = 8'h00;
    ifb.data_in = 32'h0; ifb.load = 1'b0; ifb.blank_lz = 1'b0; ifb.dp_mask = 8'h00;

    step(2);
    chk("a reset {code,an,dp,blank}", 32'({ifa.code, ifa.an, ifa.dp, ifa.blank}), 32'({4'h0, 8'hFE, 1'b1, 1'b0}));
    chk("a reset frame", 32'(ifa.frame), 32'd0);
    chk("b reset {code,an,dp,blank}", 32'({ifb.code, ifb.an, ifb.dp, ifb.blank}), 32'({4'h0, 8'hFE, 1'b1, 1'b0}));
    chk("b reset frame", 32'(ifb.frame), 32'd0);

    // 3-digit instance, one cycle per slot
    ifb.data_in  = 32'h00000021;
    ifb.load     = 1'b1;
    ifb.dp_mask  = 8'h02;
    ifb.blank_lz = btab[0].blz;
    rst_b        = 1'b0;
    for (int r = 0; r < NB; r++) begin
      @(negedge clk);
      if (r == 0) ifb.load = 1'b0;
      chk($sformatf("b row%0d {code,an,dp,blank,frame}", r),
          32'({ifb.code, ifb.an, ifb.dp, ifb.blank, ifb.frame}),
          32'({btab[r].code, btab[r].an, btab[r].dp, btab[r].blank, btab[r].frame}));
      if (r + 1 < NB) ifb.blank_lz = btab[r + 1].blz;
    end

    // 8-digit instance: release lands on the first cycle of digit 0
    rst_a = 1'b0;
    prev  = 32'h0;
    lead  = 4;
    for (int v = 0; v < NV; v++) begin
      step(lead);
      lead = 5;
      ifa.blank_lz = vtab[v].blz;
      ifa.dp_mask  = vtab[v].dpm;
      ifa.data_in  = vtab[v].value;
      ifa.load     = 1'b1;
      step(1);
      ifa.load = 1'b0;
      step(3);
      // the frame in progress must finish with the old value
      for (int d = 2; d < 8; d++) begin
        chk($sformatf("vec%0d old d%0d code", v, d), 32'(ifa.code), 32'(prev[4*d +: 4]));
        if (d < 7) step(4);
      end
      push_frame(vtab[v].value, vtab[v].blank_mask, vtab[v].dpm);
      wait_frame_a($sformatf("vec%0d", v));
      check_frame_a($sformatf("vec%0d", v));
      prev = vtab[v].value;
    end

    // two loads in one frame: the later one wins
    step(5);
    ifa.blank_lz = 1'b0;
    ifa.dp_mask  = 8'h00;
    ifa.data_in  = 32'h11111111;
    ifa.load     = 1'b1;
    step(1);
    ifa.load = 1'b0;
    step(7);
    ifa.data_in = 32'h22222222;
    ifa.load    = 1'b1;
    step(1);
    ifa.load = 1'b0;
    push_frame(32'h22222222, 8'h00, 8'h00);
    wait_frame_a("lastwins");
    check_frame_a("lastwins");

    // load on the wrap tick overrides a pending shadow value
    step(5);
    ifa.data_in = 32'h77777777;
    ifa.load    = 1'b1;
    step(1);
    ifa.load = 1'b0;
    step(26);
    ifa.data_in = 32'h00560034;
    ifa.load    = 1'b1;
    step(1);
    ifa.load = 1'b0;
    chk("bypass frame", 32'(ifa.frame), 32'd1);
    chk("bypass code", 32'(ifa.code), 32'h4);
    push_frame(32'h00560034, 8'h00, 8'h00);
    check_frame_a("bypass f0");
    push_frame(32'h00560034, 8'h00, 8'h00);
    wait_frame_a("bypass f1");
    check_frame_a("bypass f1");

    // asynchronous reset at digit 5 with a load pending
    step(5);
    ifa.data_in = 32'hDEADBEEF;
    ifa.load    = 1'b1;
    step(1);
    ifa.load = 1'b0;
    step(16);
    chk("pre-reset an", 32'(ifa.an), 32'hDF);
    rst_a = 1'b1;
    #1;
    chk("midreset {code,an,dp,blank}", 32'({ifa.code, ifa.an, ifa.dp, ifa.blank}), 32'({4'h0, 8'hFE, 1'b1, 1'b0}));
    chk("midreset frame", 32'(ifa.frame), 32'd0);
    step(2);
    rst_a = 1'b0;
    step(1);
    chk("postreset {code,an,dp,blank}", 32'({ifa.code, ifa.an, ifa.dp, ifa.blank}), 32'({4'h0, 8'hFE, 1'b1, 1'b0}));
    push_frame(32'h00000000, 8'h00, 8'h00);
    wait_frame_a("postreset");
    check_frame_a("postreset");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
